// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
// mem_arb_pkg: shared types for the CPU/loader data-RAM arbiter.
//   state_t  - sequencing FSM states
//   owner_t  - grantee encoding (0=CPU, 1=LDR)
//   PERF_W   - width of the optional performance counters (ARB_PERFCNT_EN)
//   sat_add  - saturating add used by those counters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  localparam int unsigned PERF_W = 16;

  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] v,
                                                input logic [1:0]        inc);
    logic [PERF_W:0] s;
    s = {1'b0, v} + {{(PERF_W-1){1'b0}}, inc};
    return s[PERF_W] ? '1 : s[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if: bus bundle for the arbiter.
//   cpu_* / ldr_* : requester handshake (req, we, addr, wdata, be -> ack, rdata)
//   mem_*         : single-port RAM side (en, we, addr, wdata, be <- rdata)
// Modports: master = environment (requesters + RAM), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [BE_W-1:0]   ldr_be;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
`timescale 1ns/1ps
// mem_arb_rr: combinational 2-way round-robin picker.
//   req_i[0]=CPU, req_i[1]=LDR; last_owner_i = previous grantee.
//   grant_valid_o = any request; grant_owner_o = chosen requester.
//   On a tie the requester that was not served last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_owner_i,
  output logic       grant_valid_o,
  output owner_t     grant_owner_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_owner_o = OWN_CPU;
    case (req_i)
      2'b01:   grant_owner_o = OWN_CPU;
      2'b10:   grant_owner_o = OWN_LDR;
      2'b11:   grant_owner_o = (last_owner_i == OWN_CPU) ? OWN_LDR : OWN_CPU;
      default: grant_owner_o = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares the single-port data RAM between the CPU and the
// boot/debug loader with fair round-robin and fixed-latency sequencing.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : cpu_*/ldr_* requester handshakes and mem_* RAM port
//   busy         : 1 whenever the FSM is not idle
//   owner        : current/last grantee (0=CPU, 1=LDR)
// Optional (macro ARB_PERFCNT_EN): perf_clr input and saturating 16-bit
// perf_cpu_grants / perf_ldr_grants / perf_wait_cycles outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner
`ifdef ARB_PERFCNT_EN
  ,
  input  logic                perf_clr,
  output logic [PERF_W-1:0]   perf_cpu_grants,
  output logic [PERF_W-1:0]   perf_ldr_grants,
  output logic [PERF_W-1:0]   perf_wait_cycles
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 3;

  state_t            state_q;
  owner_t            owner_q;
  owner_t            last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              ack_cpu_q;
  logic              ack_ldr_q;

  logic              gnt_valid;
  owner_t            gnt_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              go_done;

  mem_arb_rr u_rr (
    .req_i         ({bus.ldr_req, bus.cpu_req}),
    .last_owner_i  (last_q),
    .grant_valid_o (gnt_valid),
    .grant_owner_o (gnt_owner)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_be    = bus.cpu_be;
    if (gnt_owner == OWN_LDR) begin
      sel_we    = bus.ldr_we;
      sel_addr  = bus.ldr_addr;
      sel_wdata = bus.ldr_wdata;
      sel_be    = bus.ldr_be;
    end
  end

  // Single point for the transition into S_DONE so the ack/rdata capture is
  // shared between the write, RD_LAT==1 and counted-wait paths.
  always_comb begin
    go_done = ((state_q == S_ISSUE) && (we_q || (RD_LAT == 1))) ||
              ((state_q == S_WAIT) && (cnt_q == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_CPU;
      last_q    <= OWN_LDR;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      ack_cpu_q <= 1'b0;
      ack_ldr_q <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      ack_cpu_q <= 1'b0;
      ack_ldr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            owner_q  <= gnt_owner;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            be_q     <= sel_be;
            mem_en_q <= 1'b1;
            mem_we_q <= sel_we;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!go_done) begin
            cnt_q   <= CNT_W'(RD_LAT - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!go_done) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_done) begin
        state_q   <= S_DONE;
        ack_cpu_q <= (owner_q == OWN_CPU);
        ack_ldr_q <= (owner_q == OWN_LDR);
        rdata_q   <= we_q ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.cpu_ack   = ack_cpu_q;
  assign bus.ldr_ack   = ack_ldr_q;
  assign bus.cpu_rdata = ack_cpu_q ? rdata_q : '0;
  assign bus.ldr_rdata = ack_ldr_q ? rdata_q : '0;
  assign busy          = (state_q != S_IDLE);
  assign owner         = owner_q;

`ifdef ARB_PERFCNT_EN
  logic              grant_now;
  logic              cpu_wait;
  logic              ldr_wait;
  logic [PERF_W-1:0] perf_cpu_q, perf_cpu_d;
  logic [PERF_W-1:0] perf_ldr_q, perf_ldr_d;
  logic [PERF_W-1:0] perf_wait_q, perf_wait_d;

  // A requester is waiting when its req is high, it is not the active owner,
  // and it is not being granted in this idle cycle.
  always_comb begin
    grant_now   = (state_q == S_IDLE) && gnt_valid;
    cpu_wait    = bus.cpu_req && !(busy && (owner_q == OWN_CPU)) &&
                  !(grant_now && (gnt_owner == OWN_CPU));
    ldr_wait    = bus.ldr_req && !(busy && (owner_q == OWN_LDR)) &&
                  !(grant_now && (gnt_owner == OWN_LDR));
    perf_cpu_d  = sat_add(perf_cpu_q, {1'b0, grant_now && (gnt_owner == OWN_CPU)});
    perf_ldr_d  = sat_add(perf_ldr_q, {1'b0, grant_now && (gnt_owner == OWN_LDR)});
    perf_wait_d = sat_add(perf_wait_q, {1'b0, cpu_wait} + {1'b0, ldr_wait});
    if (perf_clr) begin
      perf_cpu_d  = '0;
      perf_ldr_d  = '0;
      perf_wait_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cpu_q  <= '0;
      perf_ldr_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_cpu_q  <= perf_cpu_d;
      perf_ldr_q  <= perf_ldr_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_cpu_grants  = perf_cpu_q;
  assign perf_ldr_grants  = perf_ldr_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule
